// File: rtl/mpeg_ts_pkg.sv
// Shared MPEG-2 TS constants, AFC codes and generator state encoding.
package mpeg_ts_pkg;

  localparam int unsigned TS_PACKET_LEN = 188;
  localparam int unsigned TS_HDR_LEN    = 4;

  localparam logic [7:0] TS_SYNC_BYTE  = 8'h47;
  localparam logic [7:0] TS_STUFF_BYTE = 8'hFF;

  localparam logic [1:0] AFC_RSVD    = 2'b00;
  localparam logic [1:0] AFC_PAYLOAD = 2'b01;
  localparam logic [1:0] AFC_ADAPT   = 2'b10;
  localparam logic [1:0] AFC_BOTH    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_ADAPT   = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_STUFF   = 3'd4
  } ts_gen_state_e;

endpackage

// File: rtl/ts_cc_gen.sv
// Continuity counter for the TS generator: holds the last CC and the
// one-shot error-injection latch; cc is valid from the cycle after pkt_start.
module ts_cc_gen
  import mpeg_ts_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pkt_start,
  input  logic [1:0] afc,
  input  logic       inject_cc_error,
  output logic [3:0] cc
);

  logic [3:0] cc_reg_q, cc_reg_d;
  logic       latch_q, latch_d;
  logic       has_payload_c;

  // Next CC: payload-bearing packets advance by one, or by two to inject a skip.
  always_comb begin
    cc_reg_d      = cc_reg_q;
    latch_d       = latch_q;
    has_payload_c = (afc == AFC_PAYLOAD) || (afc == AFC_BOTH);
    if (pkt_start && has_payload_c) begin
      cc_reg_d = latch_q ? (cc_reg_q + 4'd2) : (cc_reg_q + 4'd1);
      latch_d  = 1'b0;
    end
    if (inject_cc_error) begin
      latch_d = 1'b1;
    end
  end

  // CC register and injection latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cc_reg_q <= 4'hF;
      latch_q  <= 1'b0;
    end else begin
      cc_reg_q <= cc_reg_d;
      latch_q  <= latch_d;
    end
  end

  assign cc = cc_reg_q;

endmodule

// File: rtl/ts_packet_generator.sv
// Back-to-back 188-byte MPEG-2 TS packet source with valid/ready byte handshake.
module ts_packet_generator
  import mpeg_ts_pkg::*;
#(
  parameter logic [12:0] PID       = 13'h0100,
  parameter int unsigned ADAPT_LEN = 7
)(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  cfg_afc,
  input  logic        inject_cc_error,
  input  logic        ready,
  output logic [7:0]  ts_data,
  output logic        valid,
  output logic        sync,
  output logic [15:0] packet_count,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX       = 8'(TS_PACKET_LEN - 1);
  localparam logic [7:0] HDR_LEN_B      = 8'(TS_HDR_LEN);
  localparam logic [7:0] ADAPT_LEN_B    = 8'(ADAPT_LEN);
  localparam logic [7:0] ADAPT_FULL_LEN = 8'(TS_PACKET_LEN - TS_HDR_LEN - 1);

  ts_gen_state_e state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [1:0]    afc_q, afc_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          sync_q, sync_d;
  logic          busy_q, busy_d;
  logic [15:0]   count_q, count_d;
  logic          xfer_c;
  logic          pkt_start_c;
  logic [7:0]    next_idx_c;
  logic [3:0]    cc_c;

  // Adaptation field length byte for the packet's AFC.
  function automatic logic [7:0] adapt_len(input logic [1:0] afc);
    return (afc == AFC_BOTH) ? ADAPT_LEN_B : ADAPT_FULL_LEN;
  endfunction

  // Last index still inside the adaptation field (header + length byte + length).
  function automatic logic in_adapt(input logic [7:0] idx, input logic [1:0] afc);
    return afc[1] && (idx <= (HDR_LEN_B + adapt_len(afc)));
  endfunction

  // Byte value at a given packet index.
  function automatic logic [7:0] byte_at(input logic [7:0] idx, input logic [1:0] afc,
                                         input logic [3:0] cc);
    logic [7:0] b;
    if (idx == 8'd0)                 b = TS_SYNC_BYTE;
    else if (idx == 8'd1)            b = {3'b000, PID[12:8]};
    else if (idx == 8'd2)            b = PID[7:0];
    else if (idx == 8'd3)            b = {2'b00, afc, cc};
    else if (in_adapt(idx, afc)) begin
      if (idx == HDR_LEN_B)          b = adapt_len(afc);
      else if (idx == HDR_LEN_B + 8'd1) b = 8'h00;
      else                           b = TS_STUFF_BYTE;
    end
    else if (afc == AFC_RSVD)        b = TS_STUFF_BYTE;
    else if (afc == AFC_PAYLOAD)     b = idx - HDR_LEN_B;
    else                             b = idx - (HDR_LEN_B + 8'd1 + adapt_len(afc));
    return b;
  endfunction

  // Section the given index falls in.
  function automatic ts_gen_state_e state_at(input logic [7:0] idx, input logic [1:0] afc);
    ts_gen_state_e s;
    if (idx < HDR_LEN_B)          s = ST_HEADER;
    else if (in_adapt(idx, afc))  s = ST_ADAPT;
    else if (afc == AFC_RSVD)     s = ST_STUFF;
    else                          s = ST_PAYLOAD;
    return s;
  endfunction

  ts_cc_gen u_cc_gen (
    .clk             (clk),
    .reset_n         (reset_n),
    .pkt_start       (pkt_start_c),
    .afc             (cfg_afc),
    .inject_cc_error (inject_cc_error),
    .cc              (cc_c)
  );

  // Next-state and next-byte logic; a new packet may start from IDLE or right after byte 187.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    afc_d       = afc_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sync_d      = sync_q;
    busy_d      = busy_q;
    count_d     = count_q;
    pkt_start_c = 1'b0;
    xfer_c      = valid_q & ready;
    next_idx_c  = idx_q + 8'd1;

    if (state_q == ST_IDLE) begin
      pkt_start_c = enable;
    end else if (xfer_c) begin
      if (idx_q == LAST_IDX) begin
        count_d     = count_q + 16'd1;
        pkt_start_c = enable;
        state_d     = ST_IDLE;
        idx_d       = 8'd0;
        data_d      = 8'h00;
        valid_d     = 1'b0;
        sync_d      = 1'b0;
        busy_d      = 1'b0;
      end else begin
        idx_d   = next_idx_c;
        data_d  = byte_at(next_idx_c, afc_q, cc_c);
        sync_d  = 1'b0;
        state_d = state_at(next_idx_c, afc_q);
      end
    end

    if (pkt_start_c) begin
      state_d = ST_HEADER;
      idx_d   = 8'd0;
      afc_d   = cfg_afc;
      data_d  = TS_SYNC_BYTE;
      valid_d = 1'b1;
      sync_d  = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      afc_q   <= AFC_RSVD;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      afc_q   <= afc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign ts_data      = data_q;
  assign valid        = valid_q;
  assign sync         = sync_q;
  assign busy         = busy_q;
  assign packet_count = count_q;

endmodule

// File: tb/tb_ts_packet_generator.sv
// Randomized-stall bench for ts_packet_generator against a packet-level reference model.
module tb_ts_packet_generator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  cfg_afc;
  logic        inject_cc_error;
  logic        ready;
  logic [7:0]  ts_data;
  logic        valid;
  logic        sync;
  logic [15:0] packet_count;
  logic        busy;

  ts_packet_generator #(.PID(13'h0100), .ADAPT_LEN(7)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .cfg_afc         (cfg_afc),
    .inject_cc_error (inject_cc_error),
    .ready           (ready),
    .ts_data         (ts_data),
    .valid           (valid),
    .sync            (sync),
    .packet_count    (packet_count),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model and scoreboard state
  logic [1:0] plan[$];
  logic [3:0] obs_cc[$];
  logic [1:0] obs_afc[$];
  logic [7:0] exp_pkt[188];
  int         m_cc_reg;
  bit         m_latch;
  int         pkt_seen;
  int         byte_idx;
  int         stall_pct;
  int         drop_pkt;
  int         inject_pkt;
  bit         hold_prev;
  logic [7:0] hold_data;
  logic       hold_sync;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (pkt %0d byte %0d)", tag, got, exp, pkt_seen, byte_idx);
    end
  endtask

  // Expected 188 bytes for one packet, straight from the TS layout rules.
  task automatic build_packet(input logic [1:0] afc, input logic [3:0] cc);
    for (int i = 0; i < 188; i++) exp_pkt[i] = 8'hFF;
    exp_pkt[0] = 8'h47;
    exp_pkt[1] = 8'h01;
    exp_pkt[2] = 8'h00;
    exp_pkt[3] = {2'b00, afc, cc};
    case (afc)
      2'b01: for (int i = 4; i < 188; i++) exp_pkt[i] = 8'(i - 4);
      2'b10: begin exp_pkt[4] = 8'd183; exp_pkt[5] = 8'h00; end
      2'b11: begin
        exp_pkt[4] = 8'd7;
        exp_pkt[5] = 8'h00;
        for (int i = 12; i < 188; i++) exp_pkt[i] = 8'(i - 12);
      end
      default: ;
    endcase
  endtask

  // CC decision made once per packet.
  function automatic logic [3:0] model_cc(input logic [1:0] afc);
    if (afc == 2'b01 || afc == 2'b11) begin
      m_cc_reg = (m_cc_reg + (m_latch ? 2 : 1)) % 16;
      m_latch  = 1'b0;
    end
    return 4'(m_cc_reg);
  endfunction

  // Discontinuities seen across payload-bearing packets since reset.
  function automatic int loss_count();
    int errs = 0;
    bit have = 0;
    logic [3:0] last = 4'h0;
    for (int i = 0; i < obs_cc.size(); i++) begin
      if (obs_afc[i][0]) begin
        if (have && obs_cc[i] != last + 4'd1) errs++;
        last = obs_cc[i];
        have = 1;
      end
    end
    return errs;
  endfunction

  // One clock: drive stimulus at the falling edge and score the byte moved at the next rising edge.
  task automatic cycle();
    int cur_pkt;
    logic [1:0] afc_m;
    @(negedge clk);
    inject_cc_error = 1'b0;
    if (valid && hold_prev) begin
      check_eq("hold_data", ts_data, hold_data);
      check_eq("hold_sync", sync, hold_sync);
    end
    cur_pkt = pkt_seen;
    if (valid && sync && (cur_pkt + 1 < plan.size())) cfg_afc = plan[cur_pkt + 1];
    if (cur_pkt == drop_pkt && byte_idx >= 50) enable = 1'b0;
    if (cur_pkt == inject_pkt && (byte_idx == 20 || byte_idx == 40)) begin
      inject_cc_error = 1'b1;
      m_latch = 1'b1;
    end
    ready = ($urandom_range(99) >= 32'(stall_pct));
    hold_prev = valid && !ready;
    hold_data = ts_data;
    hold_sync = sync;
    if (valid && ready) begin
      if (byte_idx == 0) begin
        afc_m = (cur_pkt < plan.size()) ? plan[cur_pkt] : 2'b01;
        build_packet(afc_m, model_cc(afc_m));
        check_eq("busy", busy, 1);
      end
      check_eq("byte", ts_data, exp_pkt[byte_idx]);
      check_eq("sync", sync, byte_idx == 0);
      if (byte_idx == 3) begin
        obs_cc.push_back(ts_data[3:0]);
        obs_afc.push_back(ts_data[5:4]);
      end
      byte_idx++;
      if (byte_idx == 188) begin
        byte_idx = 0;
        pkt_seen++;
      end
    end
  endtask

  // Generate until 'target' packets since reset, dropping enable at byte 50 of the last one.
  task automatic run_until(input int target);
    int cyc = 0;
    drop_pkt = target - 1;
    cfg_afc  = plan[pkt_seen];
    enable   = 1'b1;
    cycle();
    check_eq("first_valid", valid, 1);
    while (pkt_seen < target && cyc < 200 * 188) begin
      cycle();
      cyc++;
    end
    if (pkt_seen < target) check_eq("timeout", 32'(pkt_seen), 32'(target));
    repeat (3) cycle();
    check_eq("idle_valid", valid, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("packet_count", packet_count, 16'(pkt_seen));
  endtask

  task automatic model_reset();
    m_cc_reg  = 15;
    m_latch   = 1'b0;
    pkt_seen  = 0;
    byte_idx  = 0;
    hold_prev = 1'b0;
    drop_pkt  = -1;
    inject_pkt = -1;
    plan.delete();
    obs_cc.delete();
    obs_afc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    ready = 1'b0;
    inject_cc_error = 1'b0;
    cfg_afc = 2'b01;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_sync", sync, 0);
    check_eq("rst_data", ts_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", packet_count, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_no_enable", valid, 0);
  endtask

  initial begin
    int cyc;
    do_reset();

    // Steady flow, no stalls, across the CC wrap
    stall_pct = 0;
    repeat (17) plan.push_back(2'b01);
    run_until(17);
    check_eq("cc_first", obs_cc[0], 4'h0);
    check_eq("cc_15", obs_cc[15], 4'hF);
    check_eq("cc_wrap", obs_cc[16], 4'h0);
    check_eq("count_17", packet_count, 16'd17);

    // Re-enable with random stalls; CC continues
    stall_pct = 30;
    repeat (6) plan.push_back(2'b01);
    run_until(23);
    check_eq("cc_continue", obs_cc[17], 4'h1);

    // Reset mid-packet at byte 100
    stall_pct = 20;
    repeat (2) plan.push_back(2'b01);
    cfg_afc = plan[pkt_seen];
    drop_pkt = -1;
    enable = 1'b1;
    cyc = 0;
    while (!(pkt_seen == 23 && byte_idx >= 100) && cyc < 2000) begin
      cycle();
      cyc++;
    end
    check_eq("reached_byte100", byte_idx >= 100, 1);
    reset_n = 1'b0;
    #1;
    check_eq("async_valid", valid, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_count", packet_count, 0);
    do_reset();

    // AFC mix after reset
    stall_pct = 25;
    plan.push_back(2'b01); plan.push_back(2'b10); plan.push_back(2'b11); plan.push_back(2'b01);
    run_until(4);
    check_eq("mix_cc0", obs_cc[0], 4'h0);
    check_eq("mix_cc1", obs_cc[1], 4'h0);
    check_eq("mix_cc2", obs_cc[2], 4'h1);
    check_eq("mix_cc3", obs_cc[3], 4'h2);
    check_eq("mix_afc1", obs_afc[1], 2'b10);

    // CC skip injection with a second absorbed pulse
    repeat (3) plan.push_back(2'b01);
    inject_pkt = 4;
    run_until(7);
    check_eq("inj_cc_before", obs_cc[4], 4'h3);
    check_eq("inj_cc_skip", obs_cc[5], 4'h5);
    check_eq("inj_cc_after", obs_cc[6], 4'h6);
    check_eq("loss_count", 32'(loss_count()), 32'd1);

    // Random AFC, stalls and injection
    stall_pct = 40;
    repeat (10) plan.push_back(2'($urandom_range(3)));
    inject_pkt = 7 + int'($urandom_range(4));
    run_until(17);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ts_packet_generator.md
Name: ts_packet_generator

Overview:
Transmit-side MPEG-2 TS source. Emits back-to-back 188-byte transport packets, one byte per handshake: sync byte 0x47, 4-byte header with configured PID, AFC and a continuity counter (CC), an optional adaptation field, and a deterministic payload. CC increments follow the ISO 13818-1 rules, and a deliberate CC skip can be injected. Feeds the QoS monitor path (sync/valid/ts_data byte stream) as a traffic source and loss-injection stimulus.

Parameters:
PID, 13'h0100, PID placed in header bytes 1–2.
ADAPT_LEN, 7, adaptation_field_length used when AFC=2'b11; legal range 1..182.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
enable  in  1  level; generate packets while high.
cfg_afc  in  2  adaptation_field_control for next packet; sampled at packet start.
inject_cc_error  in  1  single-cycle pulse; latched; corrupts CC of next payload-bearing packet.
ready  in  1  downstream accepts byte this cycle.
ts_data  out  8  TS byte.
valid  out  1  ts_data valid.
sync  out  1  high with valid on byte 0 (0x47) only.
packet_count  out  16  packets fully transferred; wraps at 16'hFFFF -> 0.
busy  out  1  high from packet start until last byte accepted.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. Reset takes effect immediately, including mid-packet, and clears:
  - outputs: valid=0, sync=0, ts_data=0, busy=0, packet_count=0;
  - internal: state=IDLE, byte index=0, cc_reg=4'hF, inject latch=0.
- Handshake:
  - A byte transfers on a cycle with valid && ready.
  - While valid && !ready, ts_data, sync and valid hold stable.
  - valid never drops mid-packet.
- Byte index: 0..187. Advances only on transfer.
- States:
  - IDLE: valid=0. If enable=1, sample cfg_afc, compute the packet CC, load byte 0, go to HEADER. valid=1 on the next cycle, so latency from enable to first valid is 1 cycle.
  - HEADER: bytes 0–3.
    - byte0 = 8'h47 (sync=1).
    - byte1 = {TEI=0, PUSI=0, prio=0, PID[12:8]}.
    - byte2 = PID[7:0].
    - byte3 = {2'b00, afc, cc}.
    - After byte 3: go to ADAPT if afc[1]=1, else PAYLOAD if afc=2'b01, else STUFF.
  - ADAPT:
    - byte4 = length: 183 when afc=2'b10, ADAPT_LEN when afc=2'b11.
    - byte5 = 8'h00 (flags).
    - Bytes up to index 4+length = 8'hFF.
    - Then PAYLOAD if afc=2'b11, else done.
  - PAYLOAD: byte value = (index − payload start index)[7:0], i.e. 0,1,2,… within each packet.
  - STUFF (afc=2'b00, reserved): bytes 4–187 = 8'hFF.
- End of packet: on transfer of byte 187, increment packet_count.
  - If enable=1: sample cfg_afc and present byte 0 of the next packet in the next cycle. No gap cycle; valid stays high.
  - Else go to IDLE (valid=0, busy=0).
  - Deasserting enable mid-packet does not truncate the packet.
- CC rules (decided at packet start):
  - afc ∈ {01,11}: cc = cc_reg+1 mod 16; cc_reg <= cc.
  - If the inject latch is set: cc = cc_reg+2 mod 16 instead; cc_reg <= cc; latch clears.
  - afc ∈ {00,10}: cc = cc_reg, unchanged; the latch is kept.
  - The first payload packet after reset carries CC=0. Wrap 15 -> 0 is legal.
- inject_cc_error: a pulse on the same cycle as packet start applies to the following payload packet. Pulses while the latch is set are absorbed (one skip only).
- cfg_afc changes mid-packet have no effect on the current packet.

Decomposition:
- Package mpeg_ts_pkg holds:
  - TS_SYNC_BYTE = 8'h47, TS_PACKET_LEN = 188, TS_HDR_LEN = 4, TS_STUFF_BYTE = 8'hFF;
  - AFC codes: AFC_RSVD = 2'b00, AFC_PAYLOAD = 2'b01, AFC_ADAPT = 2'b10, AFC_BOTH = 2'b11;
  - the generator state encoding.
- The loss counter shares the same package.
- One sub-module, ts_cc_gen, contains cc_reg, the inject latch and the next-CC computation. It takes inputs pkt_start and afc and outputs cc.

Test Plan:
- Reset, enable=1, cfg_afc=01, ready=1 -> first valid one cycle after enable. Bytes 47 01 00 10, then 00..B7. sync high only on byte 0. CC of packets 0..16 = 0,1,…,F,0. packet_count=17.
- Random ready stalls during afc=01 -> byte stream is identical to the no-stall case. ts_data/sync stay stable while !ready.
- Sequence afc 01,10,11,01 -> CC 0,0,1,2.
  - afc=10 packet: byte3=0x20, byte4=0xB7, byte5=0x00, rest 0xFF.
  - afc=11 packet: byte4=0x07, byte5=0x00, bytes 6..11=0xFF, payload 00..AF from byte 12.
- Pulse inject_cc_error during a payload packet with CC=3 -> next payload CC=5, following CC=6. A chained packet_loss_counter reads error_count=1.
- Drop enable at byte 50 -> packet completes to byte 187, then valid=0 and busy=0. Re-enable continues CC from the last value.
- Assert reset_n=0 at byte 100 -> valid drops immediately. After release and enable, the first packet has CC=0 and packet_count restarts from 0.
